// File: rtl/custom_wb_arb_pkg.sv
// Shared types and the round-robin scan function for the custom-unit writeback arbiter.
package custom_wb_arb_pkg;

  localparam int unsigned DefIdWidth   = 3;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned MaxUnits     = 8;

  typedef struct packed {
    logic                    valid;
    logic [DefIdWidth-1:0]   id;
    logic [DefDataWidth-1:0] rd;
  } wb_slot_t;

  // First set request after 'last', wrapping at n-1; returns 'last' when nothing is requested.
  function automatic logic [2:0] rr_next(input logic [2:0] last, input logic [7:0] req,
                                         input int unsigned n);
    logic [2:0]  g;
    logic        found;
    int unsigned idx;
    g     = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxUnits; i++) begin
      idx = (32'(last) + i) % n;
      if (!found && (i <= n) && req[idx[2:0]]) begin
        g     = idx[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/custom_wb_arbiter_if.sv
// Unit-side done/ack handshake and downstream writeback slot of the custom-unit arbiter.
interface custom_wb_arbiter_if #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_UNITS-1:0]                 unit_done;
  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   unit_id;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_rd;
  logic [NUM_UNITS-1:0]                 unit_ack;
  logic                                 out_valid;
  logic [ID_WIDTH-1:0]                  out_id;
  logic [DATA_WIDTH-1:0]                out_rd;
  logic                                 out_ack;

  // Arbiter side.
  modport slave (
    input  unit_done, unit_id, unit_rd, out_ack,
    output unit_ack, out_valid, out_id, out_rd
  );

  // Units plus writeback side.
  modport master (
    output unit_done, unit_id, unit_rd, out_ack,
    input  unit_ack, out_valid, out_id, out_rd
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request after last_grant, wrapping; reusable.
module rr_priority_picker
  import custom_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] i_req,
  input  logic [IDX_WIDTH-1:0] i_last_grant,
  output logic [NUM_UNITS-1:0] o_grant_onehot,
  output logic [IDX_WIDTH-1:0] o_grant_idx,
  output logic                 o_any_req
);
  logic [7:0] w_req8;
  logic [2:0] w_idx;

  always_comb begin
    w_req8                  = '0;
    w_req8[NUM_UNITS-1:0]   = i_req;
    w_idx                   = rr_next(3'(i_last_grant), w_req8, NUM_UNITS);
    o_grant_idx             = w_idx[IDX_WIDTH-1:0];
    o_any_req               = |i_req;
    o_grant_onehot          = '0;
    if (o_any_req) o_grant_onehot[o_grant_idx] = 1'b1;
  end
endmodule

// File: rtl/custom_wb_arbiter.sv
// Round-robin writeback arbiter for custom units into one registered slot.
// Optional conflict counter enabled by CUSTOM_WB_ARB_PERF_EN.
module custom_wb_arbiter
  import custom_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  custom_wb_arbiter_if.slave  bus
`ifdef CUSTOM_WB_ARB_PERF_EN
  ,
  output logic [31:0]         conflict_count
`endif
);
  localparam int unsigned IdxW = $clog2(NUM_UNITS);

  logic                  r_valid;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_rd;
  logic [IdxW-1:0]       r_last;

  logic [NUM_UNITS-1:0]  w_onehot;
  logic [IdxW-1:0]       w_idx;
  logic                  w_any;
  logic                  w_slot_free;
  logic                  w_grant;

  rr_priority_picker #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_WIDTH (IdxW)
  ) u_picker (
    .i_req          (bus.unit_done),
    .i_last_grant   (r_last),
    .o_grant_onehot (w_onehot),
    .o_grant_idx    (w_idx),
    .o_any_req      (w_any)
  );

  always_comb begin
    w_slot_free  = ~r_valid | bus.out_ack;
    w_grant      = w_slot_free & w_any & ~rst;
    bus.unit_ack = w_grant ? w_onehot : '0;
  end

  assign bus.out_valid = r_valid;
  assign bus.out_id    = r_id;
  assign bus.out_rd    = r_rd;

  // last_grant only moves on a grant, so idle cycles never rotate priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rd    <= '0;
      r_last  <= IdxW'(NUM_UNITS - 1);
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_id    <= bus.unit_id[w_idx];
      r_rd    <= bus.unit_rd[w_idx];
      r_last  <= w_idx;
    end else if (bus.out_ack) begin
      r_valid <= 1'b0;
    end
  end

`ifdef CUSTOM_WB_ARB_PERF_EN
  logic [31:0] r_conflict;
  logic        w_conflict;

  // With two or more requesters at most one is acked, so someone always waits.
  assign w_conflict     = $countones(bus.unit_done) >= 2;
  assign conflict_count = r_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict <= '0;
    end else if (w_conflict && (r_conflict != 32'hFFFF_FFFF)) begin
      r_conflict <= r_conflict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_custom_wb_arbiter.sv
// Scoreboard bench for custom_wb_arbiter: directed grants queue expected slot contents.
module tb_custom_wb_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  custom_wb_arbiter_if #(.NUM_UNITS(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

`ifdef CUSTOM_WB_ARB_PERF_EN
  logic [31:0] conflict_count;
`endif

  custom_wb_arbiter #(
    .NUM_UNITS  (N),
    .ID_WIDTH   (IW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CUSTOM_WB_ARB_PERF_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int u);
    exp_t e;
    e.id = bus.unit_id[u];
    e.rd = bus.unit_rd[u];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    cyc();
    rst           = 1'b1;
    bus.unit_done = '0;
    bus.out_ack   = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Monitor: each accepted slot must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", bus.out_id, e.id);
        chk("out_rd", bus.out_rd, e.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    bus.unit_done = 4'b0001;
    bus.unit_id   = '0;
    bus.unit_rd   = '0;
    bus.unit_id[0] = 3'd5;
    bus.unit_rd[0] = 32'h10;
    bus.out_ack   = 1'b0;

    // Reset values, and no ack while reset is held.
    cyc();
    #2;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_id", bus.out_id, 3'd0);
    chk("rst_rd", bus.out_rd, 32'h0);
    chk("rst_ack", bus.unit_ack, 4'b0000);

    // Test 1: first grant goes to unit 0 in the same cycle.
    cyc();
    rst = 1'b0;
    #2;
    chk("t1_ack", bus.unit_ack, 4'b0001);
    push(0);
    cyc();
    bus.unit_done = '0;
    bus.out_ack   = 1'b1;
    #2;
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_id", bus.out_id, 3'd5);
    chk("t1_rd", bus.out_rd, 32'h10);
    cyc();
    bus.out_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.unit_id[i] = IW'(i + 1);
      bus.unit_rd[i] = 32'hA0 + 32'(i);
    end

    // Test 2: all units requesting, downstream always accepting.
    do_reset();
    bus.unit_done = 4'b1111;
    bus.out_ack   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t2_ack", bus.unit_ack, 64'(1) << order[k]);
      if (k > 0) chk("t2_nobubble", bus.out_valid, 1'b1);
      push(order[k]);
      cyc();
    end
    bus.unit_done = '0;
    #2;
    chk("t2_idle_ack", bus.unit_ack, 4'b0000);
    cyc();
    bus.out_ack = 1'b0;
    #2;
    chk("t2_drained", bus.out_valid, 1'b0);

    // Test 3: full slot blocks unit 2 until accepted.
    cyc();
    bus.unit_done = 4'b0001;
    #2;
    chk("t3_fill_ack", bus.unit_ack, 4'b0001);
    push(0);
    cyc();
    bus.unit_done = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t3_blocked_ack", bus.unit_ack, 4'b0000);
      chk("t3_stable_id", bus.out_id, 3'd1);
      chk("t3_stable_rd", bus.out_rd, 32'hA0);
      cyc();
    end
    bus.out_ack = 1'b1;
    #2;
    chk("t3_ack", bus.unit_ack, 4'b0100);
    push(2);
    cyc();
    bus.unit_done = '0;
    #2;
    chk("t3_next_id", bus.out_id, 3'd3);
    cyc();
    bus.out_ack = 1'b0;

    // Test 4: last_grant=3 wraps to unit 0 ahead of unit 3.
    bus.unit_done = 4'b1000;
    #2;
    chk("t4_set_ack", bus.unit_ack, 4'b1000);
    push(3);
    cyc();
    bus.unit_done = 4'b1001;
    bus.out_ack   = 1'b1;
    #2;
    chk("t4_wrap_ack", bus.unit_ack, 4'b0001);
    push(0);
    cyc();
    bus.unit_done = '0;
    cyc();
    bus.out_ack = 1'b0;

    // Test 5: asynchronous reset discards the slot, priority restarts at unit 0.
    bus.unit_done = 4'b0100;
    #2;
    chk("t5_fill_ack", bus.unit_ack, 4'b0100);
    push(2);
    cyc();
    bus.unit_done = '0;
    #2;
    chk("t5_full", bus.out_valid, 1'b1);
    rst = 1'b1;
    bus.unit_done = 4'b0110;
    #1;
    chk("t5_async_valid", bus.out_valid, 1'b0);
    chk("t5_rst_ack", bus.unit_ack, 4'b0000);
    void'(sb.pop_back());
    cyc();
    rst = 1'b0;
    #2;
    chk("t5_restart_ack", bus.unit_ack, 4'b0010);
    push(1);
    cyc();
    bus.unit_done = 4'b0100;
    bus.out_ack   = 1'b1;
    #2;
    chk("t5_next_ack", bus.unit_ack, 4'b0100);
    push(2);
    cyc();
    bus.unit_done = '0;
    cyc();
    bus.out_ack = 1'b0;

`ifdef CUSTOM_WB_ARB_PERF_EN
    // Test 6: two persistent requesters alternate; one waits every cycle.
    do_reset();
    chk("t6_cnt_rst", conflict_count, 32'd0);
    bus.unit_done = 4'b0011;
    bus.out_ack   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t6_alt_ack", bus.unit_ack, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      push(k % 2);
      cyc();
    end
    bus.unit_done = '0;
    #2;
    chk("t6_conflicts", conflict_count, 32'd4);
    cyc();
    bus.out_ack = 1'b0;
`endif

    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/custom_wb_arbiter.md
Name: custom_wb_arbiter

Overview:
- Shares one writeback port among NUM_UNITS custom-style execution units. Each unit holds a result using the done/ack handshake and waits until the arbiter accepts it.
- Round-robin grant into a single registered output slot. Throughput is one result per cycle while the downstream side accepts.
- Sits between the custom execution units and the writeback/commit logic.

Parameters:
- NUM_UNITS, 4, number of requesting units; legal range 2..8
- ID_WIDTH, 3, width of the instruction id; matches the core's id_t width
- DATA_WIDTH, 32, result width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- unit_done  in  NUM_UNITS  per-unit "result held" flag; stays high until that unit is acked
- unit_id  in  NUM_UNITS x ID_WIDTH  per-unit id of the held result
- unit_rd  in  NUM_UNITS x DATA_WIDTH  per-unit result data
- unit_ack  out  NUM_UNITS  one-hot or zero; combinational accept of the granted unit this cycle
- out_valid  out  1  output slot holds a result
- out_id  out  ID_WIDTH  id of the held result
- out_rd  out  DATA_WIDTH  held result data
- out_ack  in  1  downstream accepts the slot this cycle; meaningful only when out_valid=1
- conflict_count  out  32  present only with the optional feature; see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_id=0, out_rd=0.
  - last_grant=NUM_UNITS-1, so unit 0 has top priority on the first arbitration.
  - unit_ack=0 while rst=1.
- slot_free = ~out_valid | out_ack.
- Grant (combinational):
  - Only when slot_free=1 and at least one unit_done bit is set.
  - Scan starts at (last_grant+1) mod NUM_UNITS, wraps at NUM_UNITS-1, and picks the first set bit.
  - unit_ack[g]=1 for the winner only; all other bits 0.
  - When slot_free=0, unit_ack=0.
- Capture on the posedge of a grant cycle:
  - out_valid<=1, out_id<=unit_id[g], out_rd<=unit_rd[g], last_grant<=g.
- Slot empties: on out_ack with no grant, out_valid<=0 and out_id/out_rd hold their values (don't-care).
- Accept and grant in the same cycle: the slot reloads with the new winner, out_valid stays 1, and there is no bubble.
- Latency: a unit's done reaches out_valid 1 cycle after grant. A unit asserting done into an idle arbiter is acked the same cycle.
- Fairness:
  - A persistently requesting unit waits at most NUM_UNITS-1 grants.
  - last_grant changes only on a grant; idle cycles do not rotate it.
- out_valid=1 with out_ack=0: out_id/out_rd are stable, unit_ack=0, and requesters stay blocked.
- The arbiter never grants a unit whose unit_done=0. unit_done deasserting without an ack is a protocol error; behaviour is undefined.
- Reset asserted mid-operation: the slot is discarded immediately and arbitration restarts at unit 0 after reset releases.

Optional Feature:
- Macro: CUSTOM_WB_ARB_PERF_EN.
- Defined:
  - conflict_count exists; it resets to 0.
  - It increments by 1 each cycle in which two or more unit_done bits are set and at least one requester is not acked. This includes cycles blocked by a full slot.
  - It saturates at 32'hFFFFFFFF.
- Undefined: neither the port nor the counter exists, and there is no other change.

Decomposition:
- Package custom_wb_arb_pkg:
  - typedef wb_slot_t {logic valid; logic [ID_WIDTH-1:0] id; logic [DATA_WIDTH-1:0] rd}.
  - Function rr_next(last, req) returning the grant index.
- Sub-module rr_priority_picker: inputs req[NUM_UNITS] and last_grant; outputs grant_onehot, grant_idx and any_req. Purely combinational and reusable by other arbiters.

Test Plan:
1. Reset release, unit_done=4'b0001, unit_id[0]=5, unit_rd[0]=32'h10 -> unit_ack=4'b0001 that cycle; next cycle out_valid=1, out_id=5, out_rd=32'h10.
2. unit_done=4'b1111 held, out_ack=1 every cycle, units re-asserting after ack -> grant order 0,1,2,3,0; one result per cycle with no bubbles.
3. Slot full, out_ack=0 for 3 cycles, unit_done=4'b0100 -> unit_ack=0 and out_* stable for 3 cycles; on the out_ack cycle unit_ack=4'b0100 and the next cycle shows unit 2's id.
4. last_grant=3 (wrap case), unit_done=4'b1001 -> unit 0 granted, not unit 3.
5. rst asserted asynchronously mid-cycle while out_valid=1 -> out_valid drops immediately with no clock edge; after release, unit_done=4'b0110 grants unit 1 first.
6. With CUSTOM_WB_ARB_PERF_EN defined, unit_done=4'b0011 for 4 cycles, out_ack=1 -> conflict_count=4 (units 1 and 0 alternate; one is always waiting).
